// File: rtl/conv_ctrl.sv
// Control FSM for a 1-D convolution engine: loads x/f memories, sequences MAC
// addresses per output, and presents each finished accumulator value downstream.
module conv_ctrl #(
  parameter int N = 128,
  parameter int M = 32,
  localparam int AX = $clog2(N),
  localparam int AF = $clog2(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid_x,
  output logic          s_ready_x,
  input  logic          s_valid_f,
  output logic          s_ready_f,
  output logic          m_valid_y,
  input  logic          m_ready_y,
  output logic          wr_en_x,
  output logic [AX-1:0] addr_x,
  output logic          wr_en_f,
  output logic [AF-1:0] addr_f,
  output logic          en_acc,
  output logic          clear_acc,
  output logic          frame_done,
  output logic [1:0]    dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and valid/data are held by the
  // source until the transfer completes.

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DRAIN   = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  localparam logic [AX:0]   X_FULL = (AX+1)'(N);
  localparam logic [AF:0]   F_FULL = (AF+1)'(M);
  localparam logic [AF-1:0] M_LAST = AF'(M-1);
  localparam logic [AX-1:0] N_LAST = AX'(N-M);

  state_t        state_q, state_d;
  logic [AX:0]   x_cnt_q, x_cnt_d;
  logic [AF:0]   f_cnt_q, f_cnt_d;
  logic [AF-1:0] m_cnt_q, m_cnt_d;
  logic [AX-1:0] n_cnt_q, n_cnt_d;
  logic          en_acc_q, clear_acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_LOAD;
      x_cnt_q     <= '0;
      f_cnt_q     <= '0;
      m_cnt_q     <= '0;
      n_cnt_q     <= '0;
      en_acc_q    <= 1'b0;
      clear_acc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_cnt_q     <= x_cnt_d;
      f_cnt_q     <= f_cnt_d;
      m_cnt_q     <= m_cnt_d;
      n_cnt_q     <= n_cnt_d;
      // Registered one cycle behind the address so the MAC sees read data.
      en_acc_q    <= (state_q == S_COMPUTE);
      clear_acc_q <= (state_q == S_COMPUTE) && (m_cnt_q == '0);
    end
  end

  always_comb begin
    state_d    = state_q;
    x_cnt_d    = x_cnt_q;
    f_cnt_d    = f_cnt_q;
    m_cnt_d    = m_cnt_q;
    n_cnt_d    = n_cnt_q;
    s_ready_x  = 1'b0;
    s_ready_f  = 1'b0;
    wr_en_x    = 1'b0;
    wr_en_f    = 1'b0;
    m_valid_y  = 1'b0;
    frame_done = 1'b0;
    addr_x     = n_cnt_q + AX'(m_cnt_q);
    addr_f     = m_cnt_q;

    case (state_q)
      S_LOAD: begin
        s_ready_x = (x_cnt_q < X_FULL);
        s_ready_f = (f_cnt_q < F_FULL);
        wr_en_x   = s_valid_x & s_ready_x;
        wr_en_f   = s_valid_f & s_ready_f;
        addr_x    = x_cnt_q[AX-1:0];
        addr_f    = f_cnt_q[AF-1:0];
        if (wr_en_x) x_cnt_d = x_cnt_q + 1'b1;
        if (wr_en_f) f_cnt_d = f_cnt_q + 1'b1;
        // Uses next-state counts so simultaneous final x and f still advance.
        if ((x_cnt_d == X_FULL) && (f_cnt_d == F_FULL)) state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (m_cnt_q == M_LAST) begin
          m_cnt_d = '0;
          state_d = S_DRAIN;
        end else begin
          m_cnt_d = m_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        m_valid_y = 1'b1;
        if (m_ready_y) begin
          if (n_cnt_q < N_LAST) begin
            n_cnt_d = n_cnt_q + 1'b1;
            state_d = S_COMPUTE;
          end else begin
            frame_done = 1'b1;
            x_cnt_d    = '0;
            f_cnt_d    = '0;
            n_cnt_d    = '0;
            state_d    = S_LOAD;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign en_acc    = en_acc_q;
  assign clear_acc = clear_acc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_ctrl.sv
// Bench for conv_ctrl: behavioural x/f memories and MAC around the controller,
// a direct-convolution scoreboard, and cycle-accurate control checks.
module tb_conv_ctrl;

  localparam int N  = 128;
  localparam int M  = 32;
  localparam int AX = $clog2(N);
  localparam int AF = $clog2(M);
  localparam int P  = N - M + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid_x, s_ready_x, s_valid_f, s_ready_f;
  logic          m_valid_y, m_ready_y;
  logic          wr_en_x, wr_en_f, en_acc, clear_acc, frame_done;
  logic [AX-1:0] addr_x;
  logic [AF-1:0] addr_f;
  logic [1:0]    dbg_state;

  logic [7:0]         x_data, f_data;
  logic signed [7:0]  mem_x [N];
  logic signed [7:0]  mem_f [M];
  logic signed [7:0]  rd_x, rd_f;
  logic signed [31:0] acc;
  logic signed [7:0]  xv [N];
  logic signed [7:0]  fv [M];
  logic [31:0]        exp_q [$];
  int                 n_cmp = 0;
  int                 n_err = 0;
  longint             cyc = 0;

  conv_ctrl #(.N(N), .M(M)) dut (
    .clk(clk), .reset(reset),
    .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
    .m_valid_y(m_valid_y), .m_ready_y(m_ready_y),
    .wr_en_x(wr_en_x), .addr_x(addr_x),
    .wr_en_f(wr_en_f), .addr_f(addr_f),
    .en_acc(en_acc), .clear_acc(clear_acc),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // clock / datapath
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en_x) mem_x[addr_x] <= x_data;
    if (wr_en_f) mem_f[addr_f] <= f_data;
    rd_x <= mem_x[addr_x];
    rd_f <= mem_f[addr_f];
    if (en_acc) acc <= clear_acc ? rd_x * rd_f : acc + rd_x * rd_f;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // scoreboard monitor: pops one expected y per output handshake
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (m_valid_y && m_ready_y) begin
        if (exp_q.size() == 0) begin
          chk("y_unexpected", acc, 32'hdead_beef);
        end else begin
          chk("y_value", acc, exp_q.pop_front());
        end
      end
    end
  end

  // kind 0: x=i, f=1 -> y[n]=M*n+M(M-1)/2; kind 1: all -128 -> M*16384; kind 2: random
  task automatic make_frame(input int kind);
    logic signed [31:0] s;
    for (int i = 0; i < N; i++)
      xv[i] = (kind == 0) ? 8'(i) : (kind == 1) ? -8'sd128 : 8'($urandom_range(0, 255));
    for (int m = 0; m < M; m++)
      fv[m] = (kind == 0) ? 8'sd1 : (kind == 1) ? -8'sd128 : 8'($urandom_range(0, 255));
    for (int n = 0; n < P; n++) begin
      if (kind == 0) begin
        exp_q.push_back(32'(M * n + M * (M - 1) / 2));
      end else if (kind == 1) begin
        exp_q.push_back(32'(M * 16384));
      end else begin
        s = 0;
        for (int m = 0; m < M; m++) s += 32'(xv[n + m]) * 32'(fv[m]);
        exp_q.push_back(s);
      end
    end
  endtask

  // driver: load x and f concurrently; pct = per-cycle valid probability
  task automatic load_frame(input int pct);
    int   xi = 0;
    int   fi = 0;
    int   guard = 0;
    logic rx, rf;
    while (!(xi == N && fi == M)) begin
      rx = (xi < N);
      rf = (fi < M);
      chk("s_ready_x_load", s_ready_x, rx);
      chk("s_ready_f_load", s_ready_f, rf);
      chk("m_valid_load", m_valid_y, 1'b0);
      s_valid_x = ($urandom_range(1, 100) <= pct);
      s_valid_f = ($urandom_range(1, 100) <= pct);
      x_data    = rx ? xv[xi] : 8'bx;
      f_data    = rf ? fv[fi] : 8'bx;
      #1;
      chk("wr_en_x", wr_en_x, s_valid_x && rx);
      chk("wr_en_f", wr_en_f, s_valid_f && rf);
      if (rx) chk("addr_x_load", addr_x, xi);
      if (rf) chk("addr_f_load", addr_f, fi);
      if (s_valid_x && rx) xi++;
      if (s_valid_f && rf) fi++;
      guard++;
      if (guard > 4000) begin
        chk("load_timeout", guard, 0);
        break;
      end
      @(negedge clk);
      #1;
    end
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
  endtask

  // driver: sequence all P outputs; mode 0 = ready held high, mode 1 = stalls
  task automatic run_outputs(input int mode);
    int            i, stalls;
    longint        prev_hs;
    logic [AX-1:0] hold_ax;
    prev_hs = 0;
    for (int j = 0; j < P; j++) begin
      i = 0;
      if (mode == 1) begin
        s_valid_x = 1'b1;
        s_valid_f = 1'b1;
        x_data    = 8'bx;
        f_data    = 8'bx;
      end
      while (!m_valid_y && i <= M + 4) begin
        chk("s_ready_x_busy", s_ready_x, 1'b0);
        chk("wr_en_x_busy", wr_en_x, 1'b0);
        chk("wr_en_f_busy", wr_en_f, 1'b0);
        if (i < M) begin
          chk("addr_x_mac", addr_x, j + i);
          chk("addr_f_mac", addr_f, i);
        end
        chk("en_acc_mac", en_acc, (i >= 1));
        chk("clear_acc_mac", clear_acc, (i == 1));
        if (mode == 1) m_ready_y = 1'($urandom_range(0, 1));
        @(negedge clk);
        #1;
        i++;
      end
      chk("y_latency", i, M + 1);
      if (!m_valid_y) return;
      chk("en_acc_out", en_acc, 1'b0);
      stalls = (mode == 0) ? 0 : (j == 5) ? 10 : $urandom_range(0, 3);
      if (stalls > 0) m_ready_y = 1'b0;
      hold_ax = addr_x;
      repeat (stalls) begin
        @(negedge clk);
        #1;
        chk("m_valid_stall", m_valid_y, 1'b1);
        chk("en_acc_stall", en_acc, 1'b0);
        chk("addr_x_stall", addr_x, hold_ax);
        chk("frame_done_stall", frame_done, 1'b0);
      end
      m_ready_y = 1'b1;
      #1;
      chk("frame_done", frame_done, (j == P - 1));
      if (mode == 0) begin
        if (j > 0) chk("y_period", 32'(cyc - prev_hs), M + 2);
        prev_hs = cyc;
      end
      @(negedge clk);
      #1;
    end
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    chk("s_ready_x_after", s_ready_x, 1'b1);
    chk("s_ready_f_after", s_ready_f, 1'b1);
    chk("m_valid_after", m_valid_y, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    s_valid_x = 1'b1;
    s_valid_f = 1'b1;
    m_ready_y = 1'b0;
    x_data    = 8'd0;
    f_data    = 8'd0;
    #1;
    chk("rst_s_ready_x", s_ready_x, 1'b1);
    chk("rst_s_ready_f", s_ready_f, 1'b1);
    chk("rst_wr_en_x", wr_en_x, 1'b1);
    chk("rst_m_valid", m_valid_y, 1'b0);
    chk("rst_en_acc", en_acc, 1'b0);
    chk("rst_clear_acc", clear_acc, 1'b0);
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;

    // frame 1: valids and ready held high, closed-form expectations
    make_frame(0);
    m_ready_y = 1'b1;
    load_frame(100);
    run_outputs(0);

    // frame 2: saturating values, random valids, downstream stalls
    make_frame(1);
    load_frame(60);
    run_outputs(1);

    // frame 3: abandoned by a reset pulse between edges mid-COMPUTE
    make_frame(2);
    load_frame(70);
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_s_ready_x", s_ready_x, 1'b1);
    chk("midrst_s_ready_f", s_ready_f, 1'b1);
    chk("midrst_m_valid", m_valid_y, 1'b0);
    chk("midrst_en_acc", en_acc, 1'b0);
    chk("midrst_clear_acc", clear_acc, 1'b0);
    s_valid_x = 1'b1;
    x_data    = 8'd0;
    #1;
    chk("midrst_wr_en_x", wr_en_x, 1'b1);
    s_valid_x = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1;
    reset = 1'b0;
    chk("postrst_m_valid", m_valid_y, 1'b0);

    // frame 4: full reload after the abandoned frame
    make_frame(2);
    load_frame(80);
    run_outputs(1);

    repeat (5) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_ctrl.md
CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 Parameter N, default 128: x vector length per frame.
REQ-002 Parameter M, default 32: filter length per frame; M < N SHALL hold.
REQ-003 Derived widths: AX = clog2(N), AF = clog2(M); outputs per frame P = N-M+1 (97 at defaults).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 s_valid_x  in  1  upstream x sample valid.
REQ-007 s_ready_x  out  1  controller accepts an x sample this cycle.
REQ-008 s_valid_f  in  1  upstream f coefficient valid.
REQ-009 s_ready_f  out  1  controller accepts an f coefficient this cycle.
REQ-010 m_valid_y  out  1  datapath accumulator holds a finished y value.
REQ-011 m_ready_y  in  1  downstream accepts y this cycle.
REQ-012 wr_en_x  out  1  x memory write strobe.
REQ-013 addr_x  out  AX  x memory address, shared by write and synchronous read.
REQ-014 wr_en_f  out  1  f memory write strobe.
REQ-015 addr_f  out  AF  f memory address, shared by write and synchronous read.
REQ-016 en_acc  out  1  datapath MAC enable.
REQ-017 clear_acc  out  1  with en_acc: acc <= product instead of acc + product.
REQ-018 frame_done  out  1  one-cycle pulse on final y handshake of a frame.

Function
REQ-019 FSM states SHALL be LOAD, COMPUTE, DRAIN, OUTPUT.
REQ-020 Counters: x_cnt 0..N, f_cnt 0..M, m_cnt 0..M-1, n_cnt 0..N-M.
REQ-021 LOAD: s_ready_x = (x_cnt < N), s_ready_f = (f_cnt < M); both decoded combinationally from state and counters.
REQ-022 LOAD: wr_en_x = s_valid_x & s_ready_x, addr_x = x_cnt, x_cnt increments on that handshake; f identical with f_cnt, addr_f, wr_en_f.
REQ-023 x and f loads SHALL proceed independently and concurrently; one side filling SHALL NOT stall the other.
REQ-024 Outside LOAD: s_ready_x = s_ready_f = wr_en_x = wr_en_f = 0; input data is ignored, including X values.
REQ-025 LOAD -> COMPUTE on the edge after which x_cnt == N and f_cnt == M, including the case where the final x and final f arrive on the same edge.
REQ-026 COMPUTE: addr_x = n_cnt + m_cnt, addr_f = m_cnt; m_cnt increments every cycle; after m_cnt == M-1 -> DRAIN and m_cnt <= 0.
REQ-027 en_acc SHALL be a register loaded with (state == COMPUTE); clear_acc a register loaded with (state == COMPUTE && m_cnt == 0); this matches the 1-cycle memory read latency.
REQ-028 DRAIN: one cycle with no address issue -> OUTPUT.
REQ-029 OUTPUT: m_valid_y = 1, en_acc = 0; the state holds indefinitely while m_ready_y = 0, with no address or counter change.
REQ-030 OUTPUT with m_ready_y = 1: if n_cnt < N-M, n_cnt increments -> COMPUTE; else frame_done = 1 (combinational) and -> LOAD with x_cnt, f_cnt, n_cnt cleared.
REQ-031 Latency: m_valid_y rises M+1 edges after the loading-complete edge or the prior y handshake; the minimum y period is M+2 cycles.
REQ-032 A new frame SHALL NOT be accepted until all P outputs have handshaken; s_ready_x and s_ready_f rise the cycle after frame_done.

Reset
REQ-033 On reset assertion, with no clock required: state = LOAD, all counters 0, en_acc = clear_acc = 0.
REQ-034 During and immediately after reset: s_ready_x = s_ready_f = 1, m_valid_y = 0, wr_en_x and wr_en_f follow the s_valid inputs.
REQ-035 Reset mid-COMPUTE or mid-OUTPUT abandons the frame; a partial y SHALL NOT be presented and the next frame reloads fully.

Verification
REQ-036 Feed 128 x and 32 f with valids held high -> f side ready drops after 32 accepts, x after 128; COMPUTE entered after edge 128; first m_valid_y 33 edges later.
REQ-037 During the first output window -> addr_f sequence 0..31 and addr_x 0..31, en_acc high for 32 cycles lagging the address by 1, clear_acc high only on the first.
REQ-038 m_ready_y held high -> 97 y handshakes, each exactly 34 cycles apart; frame_done pulses once with the 97th; s_ready_x rises the next cycle.
REQ-039 m_ready_y low for 10 cycles in OUTPUT -> m_valid_y stays 1, addr and en_acc stable, no extra accumulation; output index 5 computes addr_x 5..36.
REQ-040 Random valid/ready per cycle on all three ports over 100 frames, with a golden 8-bit signed conv model through the datapath -> zero mismatches, no writes outside LOAD.
REQ-041 Reset pulse asserted between edges mid-COMPUTE -> outputs return to reset values immediately; the next full frame produces correct y[0].
